mydesign_sweeper: RTL
=====================

# mydesign_sweeper

Exhaustive operand sweeper that drives the operand side of the registered `mydesign_top` wrapper and collects its result side.
- On `start_i`, it enumerates every `(operand_a, operand_b)` pair and tracks each pair through the wrapper's fixed pipeline latency.
- It re-joins each result with the operands that produced it and streams `{a, b, result}` beats over a valid/ready interface.
- It sits next to the DUT in exploration and characterisation builds, feeding on-chip or emulation-based truth-table capture of generated encodings.

## Interface
Parameters:
- `N_IN`, 3, operand width; must match the DUT.
- `N_OUT`, 6, result width; must match the DUT.
- `DUT_LATENCY`, 1, cycles from an `operand_*_o` register update to the matching `result_i`; must be at least 1.
- `FIFO_DEPTH`, 4, output FIFO entries; must be at least 2.

Ports (one clock; reset is asynchronous and active-high):
- `clk_ci` input 1: clock, rising edge.
- `rst_i` input 1: asynchronous active-high reset.
- `start_i` input 1: sweep request, sampled only in IDLE.
- `operand_a_o` output N_IN: to DUT `operand_a_i`.
- `operand_b_o` output N_IN: to DUT `operand_b_i`.
- `result_i` input N_OUT: from DUT `result_o`.
- `vec_valid_o` output 1: output beat valid.
- `vec_ready_i` input 1: downstream ready.
- `vec_a_o` output N_IN: operand a of the beat.
- `vec_b_o` output N_IN: operand b of the beat.
- `vec_result_o` output N_OUT: DUT result for that pair.
- `vec_last_o` output 1: final pair of the sweep.
- `busy_o` output 1: high in SWEEP or DRAIN.
- `done_o` output 1: one-cycle pulse at sweep completion.
- `checksum_o` output 32: present only with `SWEEPER_CHECKSUM_EN`.

## Operation
- **States:** IDLE, SWEEP, DRAIN, DONE. Reset enters IDLE.
- **IDLE → SWEEP:** on `start_i`. The 2·N_IN-bit pair counter clears to 0.
- **Pair encoding:** `operand_a_o` = counter[2N_IN-1:N_IN] and `operand_b_o` = counter[N_IN-1:0]. Order is a-major, b-minor.
- **Issue condition:** a pair issues in SWEEP when `fifo_count + inflight < FIFO_DEPTH` (credit check).
- **On issue:**
  - the operand registers load the pair;
  - a tag `{valid, a, b, last}` enters a DUT_LATENCY-deep shift register;
  - the counter increments.
- **Non-issue cycles:** operand registers hold and a bubble tag (valid=0) enters the shift register.
- **Result capture:** when a valid tag exits the shift register, `{a, b, last, result_i}` is pushed into the FIFO. The credit check guarantees the push never finds the FIFO full.
- **SWEEP → DRAIN:** the cycle the all-ones pair issues. That tag carries last=1.
- **DRAIN → DONE:** when inflight = 0, the FIFO is empty and the last beat has handshaked.
- **DONE:** asserts `done_o` for one cycle, then returns to IDLE.
- **Output stream:**
  - `vec_*` shows the FIFO head and `vec_valid_o` = FIFO not empty.
  - A beat pops when `vec_valid_o && vec_ready_i`.
  - Head fields stay stable while valid and not ready.
- **Simultaneous push and pop:** allowed; occupancy is unchanged.
- **Ignored inputs:** `start_i` is ignored outside IDLE.
- **Reset mid-sweep:** flushes the counter, the shift register and the FIFO immediately, with no partial beat. `done_o` does not pulse.

## Timing
- **Reset values:**
  - `operand_a_o`, `operand_b_o` = 0;
  - `vec_valid_o`, `vec_last_o`, `busy_o`, `done_o` = 0;
  - `vec_a_o`, `vec_b_o`, `vec_result_o` = 0;
  - `checksum_o` = 0.
- **First issue:** `start_i` at edge k → state SWEEP after k. Pair 0 issues at edge k+1.
- **First beat:** pair 0's tag exits and is pushed at edge k+1+DUT_LATENCY. `vec_valid_o` is first high after edge k+2+DUT_LATENCY.
- **Throughput:** one pair per cycle while `vec_ready_i` stays high, since the credit check never blocks in that case.
- **Total sweep length:** 2^(2·N_IN) beats. The pair counter wraps to 0 only via a new start.
- **Completion:** `done_o` pulses 2 cycles after the last handshake (DRAIN→DONE, then DONE→IDLE). `busy_o` falls in the same cycle `done_o` rises.

## Configuration
- **`SWEEPER_CHECKSUM_EN` defined:**
  - port `checksum_o` exists;
  - it is a wrapping 32-bit sum of the zero-extended `vec_result_o` over every handshaked beat;
  - it clears on IDLE→SWEEP and holds after DONE until the next start.
- **`SWEEPER_CHECKSUM_EN` undefined:** the port and the accumulator are absent; all other behaviour is identical.

## Test plan
Bench DUT: `mydesign_top` wrapping a 3×3 multiplier (N_IN=3, N_OUT=6, DUT_LATENCY=1); `vec_ready_i` held high unless stated.
- **Full sweep:** pulse `start_i` → exactly 64 beats; the first is a=0, b=0, result=0. Beat n has a=n>>3, b=n&7, result=a·b. Only the last beat (a=7, b=7, result=49) has `vec_last_o`=1. `done_o` pulses once.
- **Backpressure:** hold `vec_ready_i` low for 20 cycles after the first beat → the head stays frozen and `operand_*_o` stop changing after 4 outstanding pairs. On release, the sequence continues with no gaps or duplicates.
- **Random ready:** 50% random `vec_ready_i` → all 64 beats arrive in order with correct products.
- **Reset mid-sweep:** assert `rst_i` after the 10th beat → all outputs are 0 within the same cycle (asynchronous). A new start restarts at a=0, b=0.
- **Ignored start:** pulse `start_i` during SWEEP and DRAIN → no effect, and the beat count is still 64.
- **Checksum:** with `SWEEPER_CHECKSUM_EN`, after a full sweep `checksum_o` = 0x00000310 (784). A second sweep ends again at 0x310, not 0x620.

Source files
------------

// File: rtl/mydesign_sweeper.sv
// Exhaustive operand sweeper: walks every (a, b) pair through a fixed-latency DUT and
// streams {a, b, result, last} beats out of a credit-checked FIFO. Define SWEEPER_CHECKSUM_EN
// to add a running 32-bit sum of the handshaked results on checksum_o.
module mydesign_sweeper #(
   parameter int N_IN        = 3,
   parameter int N_OUT       = 6,
   parameter int DUT_LATENCY = 1,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic             clk_ci,
   input  logic             rst_i,
   input  logic             start_i,
   output logic [N_IN-1:0]  operand_a_o,
   output logic [N_IN-1:0]  operand_b_o,
   input  logic [N_OUT-1:0] result_i,
   output logic             vec_valid_o,
   input  logic             vec_ready_i,
   output logic [N_IN-1:0]  vec_a_o,
   output logic [N_IN-1:0]  vec_b_o,
   output logic [N_OUT-1:0] vec_result_o,
   output logic             vec_last_o,
   output logic             busy_o,
   output logic             done_o
`ifdef SWEEPER_CHECKSUM_EN
   ,
   output logic [31:0]      checksum_o
`endif
);

   localparam int CNT_W   = 2 * N_IN;
   localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int OCC_W   = $clog2(FIFO_DEPTH + 1);
   localparam int ENTRY_W = 2 * N_IN + 1 + N_OUT;

   typedef enum logic [1:0] {
      IDLE,
      SWEEP,
      DRAIN,
      DONE
   } state_t;

   typedef struct packed {
      logic            valid;
      logic [N_IN-1:0] a;
      logic [N_IN-1:0] b;
      logic            last;
   } tag_t;

   state_t state_q, state_d;

   logic [CNT_W-1:0] pair_cnt_q;
   logic             issue;
   logic             pair_is_last;
   logic             sweep_start;

   logic             issue_q;
   logic             last_q;
   tag_t             pipe_q [DUT_LATENCY];
   tag_t             stage_in;
   tag_t             pipe_out;

   logic [OCC_W-1:0] inflight_q;
   logic [OCC_W-1:0] fifo_count_q;
   logic [OCC_W:0]   credit_used;

   logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [ENTRY_W-1:0] head;
   logic               push, pop;
   logic               last_popped_q;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
      if (ptr == PTR_W'(FIFO_DEPTH - 1)) begin
         return '0;
      end
      return ptr + PTR_W'(1);
   endfunction

   assign sweep_start  = (state_q == IDLE) && start_i;
   assign pair_is_last = &pair_cnt_q;
   // Credits cover every pair that has been issued but not yet popped, so a push never overflows.
   assign credit_used  = {1'b0, fifo_count_q} + {1'b0, inflight_q};
   assign issue        = (state_q == SWEEP) && (credit_used < (OCC_W + 1)'(FIFO_DEPTH));

   assign stage_in = '{valid: issue_q, a: operand_a_o, b: operand_b_o, last: last_q};
   assign pipe_out = pipe_q[DUT_LATENCY-1];
   assign push     = pipe_out.valid;
   assign pop      = vec_valid_o && vec_ready_i;

   always_ff @(posedge clk_ci or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      busy_o  = 1'b0;
      done_o  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = SWEEP;
            end
         end
         SWEEP: begin
            busy_o = 1'b1;
            if (issue && pair_is_last) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            busy_o = 1'b1;
            if ((inflight_q == '0) && (fifo_count_q == '0) && last_popped_q) begin
               state_d = DONE;
            end
         end
         DONE: begin
            done_o  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // The counter parks on the all-ones pair; only a new start brings it back to zero.
   always_ff @(posedge clk_ci or posedge rst_i) begin
      if (rst_i) begin
         pair_cnt_q <= '0;
      end else if (sweep_start) begin
         pair_cnt_q <= '0;
      end else if (issue && !pair_is_last) begin
         pair_cnt_q <= pair_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_ci or posedge rst_i) begin
      if (rst_i) begin
         operand_a_o <= '0;
         operand_b_o <= '0;
         issue_q     <= 1'b0;
         last_q      <= 1'b0;
      end else begin
         issue_q <= issue;
         last_q  <= issue && pair_is_last;
         if (issue) begin
            operand_a_o <= pair_cnt_q[CNT_W-1:N_IN];
            operand_b_o <= pair_cnt_q[N_IN-1:0];
         end
      end
   end

   // The tag leaves the operand stage and then rides DUT_LATENCY stages, so its exit lines up with the matching result_i.
   always_ff @(posedge clk_ci or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DUT_LATENCY; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         pipe_q[0] <= stage_in;
         for (int i = 1; i < DUT_LATENCY; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   always_ff @(posedge clk_ci or posedge rst_i) begin
      if (rst_i) begin
         inflight_q <= '0;
      end else begin
         case ({issue, push})
            2'b10:   inflight_q <= inflight_q + OCC_W'(1);
            2'b01:   inflight_q <= inflight_q - OCC_W'(1);
            default: inflight_q <= inflight_q;
         endcase
      end
   end

   always_ff @(posedge clk_ci) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {pipe_out.a, pipe_out.b, pipe_out.last, result_i};
      end
   end

   always_ff @(posedge clk_ci or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         fifo_count_q <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= ptr_next(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_q <= ptr_next(rd_ptr_q);
         end
         case ({push, pop})
            2'b10:   fifo_count_q <= fifo_count_q + OCC_W'(1);
            2'b01:   fifo_count_q <= fifo_count_q - OCC_W'(1);
            default: fifo_count_q <= fifo_count_q;
         endcase
      end
   end

   always_ff @(posedge clk_ci or posedge rst_i) begin
      if (rst_i) begin
         last_popped_q <= 1'b0;
      end else if (sweep_start) begin
         last_popped_q <= 1'b0;
      end else if (pop && vec_last_o) begin
         last_popped_q <= 1'b1;
      end
   end

   // The storage array is not reset, so the beat fields are masked to zero whenever the FIFO is empty.
   assign head         = mem_q[rd_ptr_q];
   assign vec_valid_o  = (fifo_count_q != '0);
   assign vec_a_o      = vec_valid_o ? head[ENTRY_W-1 -: N_IN]      : '0;
   assign vec_b_o      = vec_valid_o ? head[N_OUT+N_IN -: N_IN]     : '0;
   assign vec_last_o   = vec_valid_o ? head[N_OUT]                  : 1'b0;
   assign vec_result_o = vec_valid_o ? head[N_OUT-1:0]              : '0;

`ifdef SWEEPER_CHECKSUM_EN
   logic [31:0] checksum_q;

   always_ff @(posedge clk_ci or posedge rst_i) begin
      if (rst_i) begin
         checksum_q <= '0;
      end else if (sweep_start) begin
         checksum_q <= '0;
      end else if (pop) begin
         checksum_q <= checksum_q + 32'(vec_result_o);
      end
   end

   assign checksum_o = checksum_q;
`else
   // Default build carries no result accumulator.
`endif

endmodule
